// File: rtl/devil_snoop_responder_mr.sv
// Multi-rule ACE snoop responder: matches incoming AC snoops against rule slots and
// shapes the CR/CD reply (delay insertion, dummy replies on miss, one-shot tracking).
`timescale 1ns/1ps
module devil_snoop_responder_mr #(
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned C_ACE_ADDR_WIDTH = 44,
  parameter int unsigned NUM_RULES        = 4,
  parameter int unsigned DELAY_WIDTH      = 16,
  parameter int unsigned CD_BEATS         = 4
) (
  input  logic                                    ace_aclk,
  input  logic                                    ace_aresetn,
  input  logic                                    i_enable,
  input  logic                                    i_acvalid,
  output logic                                    o_acready,
  input  logic [C_ACE_ADDR_WIDTH-1:0]             i_acaddr,
  input  logic [3:0]                              i_acsnoop,
  input  logic [NUM_RULES-1:0]                    i_rule_en,
  input  logic [NUM_RULES-1:0]                    i_rule_ac_chk,
  input  logic [NUM_RULES-1:0]                    i_rule_addr_chk,
  input  logic [4*NUM_RULES-1:0]                  i_rule_acsnoop,
  input  logic [C_ACE_ADDR_WIDTH*NUM_RULES-1:0]   i_rule_base,
  input  logic [C_ACE_ADDR_WIDTH*NUM_RULES-1:0]   i_rule_size,
  input  logic [DELAY_WIDTH*NUM_RULES-1:0]        i_rule_delay,
  input  logic [2*NUM_RULES-1:0]                  i_rule_point,
  input  logic [NUM_RULES-1:0]                    i_rule_cont,
  input  logic                                    i_clear_fired,
  input  logic [C_ACE_DATA_WIDTH-1:0]             i_fake_data,
  output logic                                    o_crvalid,
  input  logic                                    i_crready,
  output logic [4:0]                              o_crresp,
  output logic                                    o_cdvalid,
  input  logic                                    i_cdready,
  output logic [C_ACE_DATA_WIDTH-1:0]             o_cddata,
  output logic                                    o_cdlast,
  output logic                                    o_hit,
  output logic [2:0]                              o_hit_idx,
  output logic [NUM_RULES-1:0]                    o_fired,
  output logic                                    o_end,
  output logic [2:0]                              o_state
);

  localparam int unsigned AW  = C_ACE_ADDR_WIDTH;
  localparam int unsigned DW  = C_ACE_DATA_WIDTH;
  localparam int unsigned NR  = NUM_RULES;
  localparam int unsigned DLW = DELAY_WIDTH;
  localparam int unsigned BW  = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(CD_BEATS - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'((CD_BEATS > 1) ? CD_BEATS - 2 : 0);
  localparam bit SINGLE_BEAT = (CD_BEATS == 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MATCH = 3'd1,
    ST_DELAY = 3'd2,
    ST_CR    = 3'd3,
    ST_CD    = 3'd4,
    ST_END   = 3'd5
  } state_t;

  state_t state_q, state_d, ret_q, ret_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [3:0]     snoop_q, snoop_d;
  logic           hit_q, hit_d, cont_q, cont_d;
  logic [2:0]     idx_q, idx_d;
  logic [DLW-1:0] dly_q, dly_d, cnt_q, cnt_d;
  logic [1:0]     pt_q, pt_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [NR-1:0]  fired_q, fired_d;
  logic           acready_q, acready_d, crvalid_q, crvalid_d;
  logic           cdvalid_q, cdvalid_d, cdlast_q, cdlast_d, end_q, end_d;
  logic [4:0]     crresp_q, crresp_d;
  logic [DW-1:0]  cddata_q, cddata_d;

  // Per-rule eligibility; window check in AW+1 bits so base+size cannot wrap
  logic [NR-1:0] elig;
  logic [AW:0]   a_w, b_w, s_w;
  logic          in_win;
  assign a_w = {1'b0, addr_q};

  always_comb begin
    elig   = '0;
    b_w    = '0;
    s_w    = '0;
    in_win = 1'b0;
    for (int r = 0; r < NR; r++) begin
      b_w    = {1'b0, i_rule_base[r*AW +: AW]};
      s_w    = {1'b0, i_rule_size[r*AW +: AW]};
      in_win = (a_w >= b_w) && (a_w < (b_w + s_w));
      elig[r] = i_rule_en[r]
             && (i_rule_cont[r] || !fired_q[r])
             && (!i_rule_ac_chk[r] || (snoop_q == i_rule_acsnoop[r*4 +: 4]))
             && (!i_rule_addr_chk[r] || in_win);
    end
  end

  // Lowest eligible index wins
  logic           m_hit, m_cont;
  logic [2:0]     m_idx;
  logic [DLW-1:0] m_dly;
  logic [1:0]     m_pt;

  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_dly  = '0;
    m_pt   = '0;
    m_cont = 1'b0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (elig[r]) begin
        m_hit  = 1'b1;
        m_idx  = 3'(r);
        m_dly  = i_rule_delay[r*DLW +: DLW];
        m_pt   = i_rule_point[r*2 +: 2];
        m_cont = i_rule_cont[r];
      end
    end
  end

  logic pt2_eff, pt3_eff;
  assign pt2_eff = (pt_q == 2'd2) || ((pt_q == 2'd3) && SINGLE_BEAT);
  assign pt3_eff = (pt_q == 2'd3) && !SINGLE_BEAT;

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    pt_d      = pt_q;
    cont_d    = cont_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    fired_d   = i_clear_fired ? '0 : fired_q;
    acready_d = 1'b0;
    crvalid_d = 1'b0;
    crresp_d  = '0;
    cdvalid_d = 1'b0;
    cdlast_d  = 1'b0;
    cddata_d  = '0;
    end_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acready_q && i_acvalid) begin
          addr_d  = i_acaddr;
          snoop_d = i_acsnoop;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        hit_d  = m_hit;
        idx_d  = m_idx;
        dly_d  = m_dly;
        pt_d   = m_pt;
        cont_d = m_cont;
        cnt_d  = m_dly;
        beat_d = '0;
        if (m_hit && (m_pt == 2'd1) && (m_dly != '0)) begin
          state_d = ST_DELAY;
          ret_d   = ST_CR;
        end else begin
          state_d = ST_CR;
        end
      end
      ST_DELAY: begin
        cnt_d = cnt_q - DLW'(1);
        if (cnt_q <= DLW'(1)) state_d = ret_q;
      end
      ST_CR: begin
        if (i_crready) begin
          if (!hit_q) begin
            state_d = ST_END;
          end else if (pt2_eff && (dly_q != '0)) begin
            state_d = ST_DELAY;
            ret_d   = ST_CD;
            cnt_d   = dly_q;
          end else begin
            state_d = ST_CD;
          end
        end
      end
      ST_CD: begin
        if (i_cdready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_END;
          end else begin
            beat_d = beat_q + BW'(1);
            if (pt3_eff && (dly_q != '0) && (beat_q == PRE_LAST)) begin
              state_d = ST_DELAY;
              ret_d   = ST_CD;
              cnt_d   = dly_q;
            end
          end
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        hit_d   = 1'b0;
        idx_d   = '0;
        if (hit_q && !cont_q) begin
          for (int r = 0; r < NR; r++) begin
            if (idx_q == 3'(r)) fired_d[r] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acready_d = (state_d == ST_IDLE) && i_enable && i_acvalid;
    crvalid_d = (state_d == ST_CR);
    crresp_d  = (state_d == ST_CR) ? {4'b0000, hit_d} : 5'b00000;
    cdvalid_d = (state_d == ST_CD);
    cdlast_d  = (state_d == ST_CD) && (beat_d == LAST_BEAT);
    cddata_d  = (state_d == ST_CD) ? i_fake_data : '0;
    end_d     = (state_d == ST_END);
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      dly_q     <= '0;
      pt_q      <= '0;
      cont_q    <= 1'b0;
      cnt_q     <= '0;
      beat_q    <= '0;
      fired_q   <= '0;
      acready_q <= 1'b0;
      crvalid_q <= 1'b0;
      crresp_q  <= '0;
      cdvalid_q <= 1'b0;
      cdlast_q  <= 1'b0;
      cddata_q  <= '0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      pt_q      <= pt_d;
      cont_q    <= cont_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      fired_q   <= fired_d;
      acready_q <= acready_d;
      crvalid_q <= crvalid_d;
      crresp_q  <= crresp_d;
      cdvalid_q <= cdvalid_d;
      cdlast_q  <= cdlast_d;
      cddata_q  <= cddata_d;
      end_q     <= end_d;
    end
  end

  assign o_acready = acready_q;
  assign o_crvalid = crvalid_q;
  assign o_crresp  = crresp_q;
  assign o_cdvalid = cdvalid_q;
  assign o_cdlast  = cdlast_q;
  assign o_cddata  = cddata_q;
  assign o_hit     = hit_q;
  assign o_hit_idx = idx_q;
  assign o_fired   = fired_q;
  assign o_end     = end_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_devil_snoop_responder_mr.sv
// Directed bench for devil_snoop_responder_mr: rule matching, delay points, one-shot
// tracking, handshake stalls, reset abort and enable gating.
`timescale 1ns/1ps
module tb_devil_snoop_responder_mr;

  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 44;
  localparam int unsigned NR  = 4;
  localparam int unsigned DLW = 16;
  localparam int unsigned NB  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, acvalid, crready, cdready, clear_fired;
  logic [AW-1:0] acaddr;
  logic [3:0] acsnoop;
  logic [NR-1:0] rule_en, rule_ac_chk, rule_addr_chk, rule_cont;
  logic [4*NR-1:0] rule_acsnoop;
  logic [AW*NR-1:0] rule_base, rule_size;
  logic [DLW*NR-1:0] rule_delay;
  logic [2*NR-1:0] rule_point;
  logic [DW-1:0] fake_data;

  logic o_acready, o_crvalid, o_cdvalid, o_cdlast, o_hit, o_end;
  logic [4:0] o_crresp;
  logic [DW-1:0] o_cddata;
  logic [2:0] o_hit_idx, o_state;
  logic [NR-1:0] o_fired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  devil_snoop_responder_mr #(
    .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW), .NUM_RULES(NR),
    .DELAY_WIDTH(DLW), .CD_BEATS(NB)
  ) dut (
    .ace_aclk(clk), .ace_aresetn(rst_n), .i_enable(enable),
    .i_acvalid(acvalid), .o_acready(o_acready), .i_acaddr(acaddr), .i_acsnoop(acsnoop),
    .i_rule_en(rule_en), .i_rule_ac_chk(rule_ac_chk), .i_rule_addr_chk(rule_addr_chk),
    .i_rule_acsnoop(rule_acsnoop), .i_rule_base(rule_base), .i_rule_size(rule_size),
    .i_rule_delay(rule_delay), .i_rule_point(rule_point), .i_rule_cont(rule_cont),
    .i_clear_fired(clear_fired), .i_fake_data(fake_data),
    .o_crvalid(o_crvalid), .i_crready(crready), .o_crresp(o_crresp),
    .o_cdvalid(o_cdvalid), .i_cdready(cdready), .o_cddata(o_cddata), .o_cdlast(o_cdlast),
    .o_hit(o_hit), .o_hit_idx(o_hit_idx), .o_fired(o_fired), .o_end(o_end), .o_state(o_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rule(input int r, input bit en, input bit ac, input bit ad,
                          input logic [3:0] sn, input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic [DLW-1:0] d, input logic [1:0] p, input bit c);
    rule_en[r]             = en;
    rule_ac_chk[r]         = ac;
    rule_addr_chk[r]       = ad;
    rule_acsnoop[r*4 +: 4] = sn;
    rule_base[r*AW +: AW]  = b;
    rule_size[r*AW +: AW]  = s;
    rule_delay[r*DLW +: DLW] = d;
    rule_point[r*2 +: 2]   = p;
    rule_cont[r]           = c;
  endtask

  // Raise AC and return on the MATCH-cycle negedge
  task automatic ac_hs(input logic [AW-1:0] a, input logic [3:0] s);
    bit got;
    got = 1'b0;
    acaddr  = a;
    acsnoop = s;
    acvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_acready) begin
        got = 1'b1;
        break;
      end
    end
    chk("ac_handshake", 128'(got), 128'(1));
    @(negedge clk);
    acvalid = 1'b0;
  endtask

  task automatic wait_cr(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (o_crvalid) break;
    end
  endtask

  // With crready/cdready high, follow the reply from the visible CR beat to o_end
  task automatic finish_txn(output int beats, output int last_at, output int gaps,
                            output int pre, output bit saw_end, output bit data_ok);
    beats = 0; last_at = 0; gaps = 0; pre = 0; saw_end = 1'b0; data_ok = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_end) begin
        saw_end = 1'b1;
        break;
      end
      if (o_cdvalid) begin
        beats++;
        if (o_cdlast) last_at = (last_at == 0) ? beats : -1;
        if (o_cddata !== fake_data) data_ok = 1'b0;
      end else if (beats == 0) begin
        pre++;
      end else begin
        gaps++;
      end
    end
  endtask

  int lat, beats, last_at, gaps, pre;
  bit saw_end, data_ok, flag;

  initial begin
    rst_n = 1'b0; enable = 1'b0; acvalid = 1'b0; crready = 1'b0; cdready = 1'b0;
    clear_fired = 1'b0; acaddr = '0; acsnoop = '0;
    rule_en = '0; rule_ac_chk = '0; rule_addr_chk = '0; rule_cont = '0;
    rule_acsnoop = '0; rule_base = '0; rule_size = '0; rule_delay = '0; rule_point = '0;
    fake_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'({o_acready, o_crvalid, o_crresp, o_cdvalid, o_cdlast, o_hit,
                              o_hit_idx, o_fired, o_end, o_state}), 128'(0));
    chk("reset_cddata", o_cddata, 128'(0));
    rst_n = 1'b1; enable = 1'b1; crready = 1'b1; cdready = 1'b1;
    @(negedge clk);

    // Rule0 unfiltered, delay 3 before CR, continuous
    set_rule(0, 1, 0, 0, 4'h0, '0, '0, 16'd3, 2'd1, 1);
    ac_hs(44'h0_0001_2340, 4'h0);
    chk("t1_match_state", 128'(o_state), 128'(1));
    wait_cr(lat);
    chk("t1_cr_latency", 128'(lat), 128'(4));
    chk("t1_crresp", 128'(o_crresp), 128'(5'b00001));
    chk("t1_hit_idx", 128'({o_hit, o_hit_idx}), 128'({1'b1, 3'd0}));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t1_beats", 128'(beats), 128'(4));
    chk("t1_last_at", 128'(last_at), 128'(4));
    chk("t1_gaps_pre", 128'(gaps + pre), 128'(0));
    chk("t1_end_data", 128'({saw_end, data_ok}), 128'(2'b11));
    @(negedge clk);
    chk("t1_fired", 128'(o_fired), 128'(0));
    chk("t1_idle", 128'({o_state, o_hit}), 128'(0));

    // Rule1 one-shot, acsnoop filter = 1
    set_rule(0, 0, 0, 0, 4'h0, '0, '0, 16'd0, 2'd0, 0);
    set_rule(1, 1, 1, 0, 4'h1, '0, '0, 16'd0, 2'd0, 0);
    ac_hs(44'h0_0000_0080, 4'h1);
    wait_cr(lat);
    chk("t2a_cr_latency", 128'(lat), 128'(1));
    chk("t2a_hit", 128'({o_crresp, o_hit, o_hit_idx}), 128'({5'b00001, 1'b1, 3'd1}));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t2a_beats", 128'(beats), 128'(4));
    @(negedge clk);
    chk("t2a_fired", 128'(o_fired), 128'(4'b0010));
    ac_hs(44'h0_0000_0080, 4'h1);
    wait_cr(lat);
    chk("t2b_miss", 128'({o_crresp, o_hit}), 128'(0));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t2b_no_cd", 128'({beats, 7'(0), saw_end}), 128'({32'd0, 7'(0), 1'b1}));
    @(negedge clk);
    clear_fired = 1'b1;
    @(negedge clk);
    clear_fired = 1'b0;
    chk("t2c_cleared", 128'(o_fired), 128'(0));
    ac_hs(44'h0_0000_0080, 4'h1);
    wait_cr(lat);
    chk("t2d_rehit", 128'({o_crresp, o_hit_idx}), 128'({5'b00001, 3'd1}));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    @(negedge clk);
    chk("t2d_fired", 128'(o_fired), 128'(4'b0010));

    // Rules 0 and 2 on the same window
    set_rule(1, 0, 1, 0, 4'h1, '0, '0, 16'd0, 2'd0, 0);
    set_rule(0, 1, 0, 1, 4'h0, 44'h1000, 44'h100, 16'd0, 2'd0, 1);
    set_rule(2, 1, 0, 1, 4'h0, 44'h1000, 44'h100, 16'd0, 2'd0, 1);
    ac_hs(44'h10FF, 4'h0);
    wait_cr(lat);
    chk("t3a_top_of_window", 128'({o_crresp, o_hit, o_hit_idx}), 128'({5'b00001, 1'b1, 3'd0}));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t3a_beats", 128'(beats), 128'(4));
    ac_hs(44'h1100, 4'h0);
    wait_cr(lat);
    chk("t3b_past_window", 128'({o_crresp, o_hit}), 128'(0));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    set_rule(0, 1, 0, 1, 4'h0, 44'h1000, 44'h0, 16'd0, 2'd0, 1);
    ac_hs(44'h1000, 4'h0);
    wait_cr(lat);
    chk("t3c_rule2_wins", 128'({o_hit, o_hit_idx}), 128'({1'b1, 3'd2}));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    set_rule(2, 1, 0, 1, 4'h0, 44'h1000, 44'h0, 16'd0, 2'd0, 1);
    ac_hs(44'h1000, 4'h0);
    wait_cr(lat);
    chk("t3d_size0_miss", 128'({o_crresp, o_hit}), 128'(0));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t3d_no_cd", 128'(beats), 128'(0));

    // Point 3: delay before the last beat
    set_rule(2, 0, 0, 0, 4'h0, '0, '0, 16'd0, 2'd0, 0);
    set_rule(0, 1, 0, 0, 4'h0, '0, '0, 16'd5, 2'd3, 1);
    ac_hs(44'h2000, 4'h0);
    wait_cr(lat);
    chk("t4_cr_latency", 128'(lat), 128'(1));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t4_beats", 128'(beats), 128'(4));
    chk("t4_last_at", 128'(last_at), 128'(4));
    chk("t4_gap_before_last", 128'(gaps), 128'(5));
    chk("t4_pre", 128'(pre), 128'(0));

    // CR stall, then reset while CD is stalled
    set_rule(0, 1, 0, 0, 4'h0, '0, '0, 16'd0, 2'd0, 1);
    crready = 1'b0;
    ac_hs(44'h3000, 4'h0);
    wait_cr(lat);
    chk("t5_cr_latency", 128'(lat), 128'(1));
    flag = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(o_crvalid && (o_crresp == 5'b00001))) flag = 1'b0;
    end
    chk("t5_cr_stable", 128'(flag), 128'(1));
    cdready = 1'b0;
    crready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_cd_stalled", 128'({o_cdvalid, o_state}), 128'({1'b1, 3'd4}));
    chk("t5_fired_before_rst", 128'(o_fired), 128'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 128'({o_acready, o_crvalid, o_crresp, o_cdvalid, o_cdlast, o_hit,
                                 o_hit_idx, o_fired, o_end, o_state}), 128'(0));
    chk("t5_reset_cddata", o_cddata, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cdready = 1'b1;

    // Enable gating of AC, enable drop mid-DELAY
    enable  = 1'b0;
    acvalid = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_acready) flag = 1'b1;
    end
    chk("t6_acready_gated", 128'(flag), 128'(0));
    set_rule(0, 1, 0, 0, 4'h0, '0, '0, 16'd8, 2'd1, 1);
    enable = 1'b1;
    ac_hs(44'h4000, 4'h0);
    @(negedge clk);
    chk("t6_in_delay", 128'(o_state), 128'(2));
    enable = 1'b0;
    wait_cr(lat);
    chk("t6_cr_latency", 128'(lat), 128'(8));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t6_completes", 128'({beats, 7'(0), saw_end}), 128'({32'd4, 7'(0), 1'b1}));

    // AC accepted right after END
    enable  = 1'b1;
    acvalid = 1'b1;
    @(negedge clk);
    chk("t7_acready_after_end", 128'({o_acready, o_state}), 128'({1'b1, 3'd0}));
    @(negedge clk);
    acvalid = 1'b0;
    chk("t7_match", 128'(o_state), 128'(1));
    wait_cr(lat);
    chk("t7_cr_latency", 128'(lat), 128'(9));
    finish_txn(beats, last_at, gaps, pre, saw_end, data_ok);
    chk("t7_end", 128'(saw_end), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
